// File: rtl/fft_input_loader.sv
// Front end of the FFT: loads one frame of complex samples into the working RAM
// in bit-reversed order, then hands the RAM to the AGU until it reports fft_done.
module fft_input_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int N_POINTS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  start,
    input  logic                  fft_done,
    output logic                  busy,
    output logic                  frame_err
);

    typedef enum logic [1:0] {
        LOAD,
        FLUSH,
        START,
        WAIT
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(N_POINTS - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH-1:0] rev_addr;
    logic                  accept;
    logic                  cnt_at_last;
    logic                  good_end;
    logic                  bad_end;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (good_end) state_next = FLUSH;
            FLUSH:   state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (fft_done) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // A frame ends on an in_last or on the N-th sample; it is only good when both coincide.
    always_comb begin
        in_ready    = arst_n && (state == LOAD);
        accept      = in_valid && in_ready;
        cnt_at_last = (cnt == LAST_IDX);
        good_end    = accept && in_last && cnt_at_last;
        bad_end     = accept && (in_last != cnt_at_last);
    end

    always_comb begin
        rev_addr = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            rev_addr[i] = cnt[ADDR_WIDTH-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt       <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mem_wr    <= accept;
            frame_err <= bad_end;
            start     <= (state == FLUSH);
            busy      <= (state_next == WAIT);
            if (accept) begin
                mem_addr  <= rev_addr;
                mem_wdata <= in_data;
                if (in_last || cnt_at_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: stimulus pushes expected writes, start and
// frame_err pulses with their cycle stamps; a negedge monitor pops and compares.
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        mem_wr;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        start;
    logic        fft_done = 1'b0;
    logic        busy;
    logic        frame_err;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  wr_q[$];
    int   start_q[$];
    int   err_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic [2:0] brev [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    fft_input_loader #(.DATA_WIDTH(32), .N_POINTS(8), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .start     (start),
        .fft_done  (fft_done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writes, start and frame_err each carry the cycle in which they must appear.
    always @(negedge clk) begin
        wr_t e;
        int  c;
        if (mem_wr) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: addr %0h data %0h at cycle %0d, none expected", mem_addr, mem_wdata, cyc);
            end else begin
                e = wr_q.pop_front();
                checkOutput("write_cycle", cyc, e.cyc);
                checkOutput("write_addr", {29'b0, mem_addr}, {29'b0, e.addr});
                checkOutput("write_data", mem_wdata, e.data);
            end
        end
        if (start) begin
            if (start_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_start: start at cycle %0d, none expected", cyc);
            end else begin
                c = start_q.pop_front();
                checkOutput("start_cycle", cyc, c);
            end
        end
        if (frame_err) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame_err: pulse at cycle %0d, none expected", cyc);
            end else begin
                c = err_q.pop_front();
                checkOutput("frame_err_cycle", cyc, c);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] data, input logic last);
        int c;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        c = cyc;
        checkOutput("in_ready_load", {31'b0, in_ready}, 32'd1);
        wr_q.push_back('{c + 1, brev[exp_cnt], data});
        if (last != (exp_cnt == 7)) begin
            err_q.push_back(c + 1);
            exp_cnt = 0;
        end else if (last) begin
            start_q.push_back(c + 2);
            exp_cnt = 0;
        end else begin
            exp_cnt++;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic sendFrame(input logic [31:0] base, input int gap);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(base + i, (i == 7));
            if (gap > 0 && i != 7) idle(gap);
        end
    endtask

    // Called right after the last accept: checks the hand-off and releases the loader.
    task automatic finishFft;
        int k;
        idle(1);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd0);
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        repeat (3) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            checkOutput("wait_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("wait_busy", {31'b0, busy}, 32'd1);
        end
        in_valid = 1'b0;
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        checkOutput("done_busy", {31'b0, busy}, 32'd0);
        checkOutput("done_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic applyReset;
        @(negedge clk);
        arst_n   = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        fft_done = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        checkOutput("rst_mem_addr", {29'b0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_start", {31'b0, start}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_frame_err", {31'b0, frame_err}, 32'd0);
        arst_n  = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] reset");
        applyReset();

        $display("[TB] back-to-back frame");
        sendFrame(32'h0, 0);
        finishFft();

        $display("[TB] frame with toggling valid");
        sendFrame(32'h0, 1);
        finishFft();

        $display("[TB] early in_last");
        applyStimulus(32'h10, 1'b0);
        applyStimulus(32'h11, 1'b0);
        applyStimulus(32'h12, 1'b1);
        idle(2);
        checkOutput("err_in_ready", {31'b0, in_ready}, 32'd1);
        sendFrame(32'h20, 0);
        finishFft();

        $display("[TB] missing in_last");
        for (int i = 0; i < 8; i++) applyStimulus(32'h30 + i, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(32'h40 + i, (i == 7));
        finishFft();

        $display("[TB] fft_done while loading");
        @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        checkOutput("stray_done_busy", {31'b0, busy}, 32'd0);
        checkOutput("stray_done_in_ready", {31'b0, in_ready}, 32'd1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 5; i++) applyStimulus(32'h50 + i, 1'b0);
        applyReset();
        sendFrame(32'h60, 0);
        finishFft();

        idle(5);
        checkOutput("writes_outstanding", wr_q.size(), 32'd0);
        checkOutput("starts_outstanding", start_q.size(), 32'd0);
        checkOutput("errs_outstanding", err_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
